// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared sizing constants and FSM encoding for the instruction loader
package loader_pkg;

   localparam int MEM_BYTES = 4096;
   localparam int ADDR_W    = 12;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/instruction_loader_if.sv
// rtl/instruction_loader_if.sv - host load/fetch bus of the instruction loader
interface instruction_loader_if #(
   parameter int ADDR_W = loader_pkg::ADDR_W
);
   logic              start;
   logic [ADDR_W-1:0] base_addr;
   logic              word_valid;
   logic [31:0]       word_data;
   logic              word_last;
   logic              word_ready;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] next_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic [31:0]       rd_data;

   modport master (
      output start, base_addr, word_valid, word_data, word_last, rd_addr,
      input  word_ready, busy, done, err, next_addr, rd_data
   );

   modport slave (
      input  start, base_addr, word_valid, word_data, word_last, rd_addr,
      output word_ready, busy, done, err, next_addr, rd_data
   );
endinterface

// File: rtl/byte_memory.sv
// rtl/byte_memory.sv - byte array with one synchronous write port and four combinational read ports
module byte_memory #(
   parameter int MEM_BYTES = loader_pkg::MEM_BYTES,
   parameter int ADDR_W    = loader_pkg::ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr0,
   input  logic [ADDR_W-1:0] raddr1,
   input  logic [ADDR_W-1:0] raddr2,
   input  logic [ADDR_W-1:0] raddr3,
   output logic [7:0]        rdata0,
   output logic [7:0]        rdata1,
   output logic [7:0]        rdata2,
   output logic [7:0]        rdata3
);
   logic [7:0] mem [MEM_BYTES];

   // Contents are deliberately never reset; reads see the old byte during a write.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata0 = mem[raddr0];
   assign rdata1 = mem[raddr1];
   assign rdata2 = mem[raddr2];
   assign rdata3 = mem[raddr3];
endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - accepts 32-bit words and stores them big-endian, one byte per cycle
module instruction_loader #(
   parameter int MEM_BYTES = loader_pkg::MEM_BYTES,
   parameter int ADDR_W    = loader_pkg::ADDR_W
) (
   input logic                 clk,
   input logic                 reset,
   instruction_loader_if.slave bus
);
   import loader_pkg::state_t;
   import loader_pkg::S_IDLE;
   import loader_pkg::S_LOAD;
   import loader_pkg::S_WRITE;
   import loader_pkg::S_DONE;

   // Highest byte address at which a whole word still fits without wrapping.
   localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(MEM_BYTES - 4);

   state_t          state_q, state_d;
   // One extra bit so the pointer can sit just past the top of memory instead of wrapping to 0.
   logic [ADDR_W:0] ptr_q;
   logic [1:0]      cnt_q;
   logic            err_q;
   logic [31:0]     word_q;
   logic            last_q;
   logic            overflow;
   logic            we;
   logic [7:0]      wbyte;
   logic [7:0]      rb0, rb1, rb2, rb3;

   assign overflow = (ptr_q > LAST_WORD);
   // Reset in a write cycle must suppress that cycle's byte.
   assign we       = (state_q == S_WRITE) && !reset;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_d        = state_q;
      bus.word_ready = 1'b0;
      bus.done       = 1'b0;
      bus.busy       = (state_q != S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (bus.start) state_d = S_LOAD;
         end
         S_LOAD: begin
            bus.word_ready = 1'b1;
            if (bus.word_valid) state_d = overflow ? S_DONE : S_WRITE;
         end
         S_WRITE: begin
            if (cnt_q == 2'd3) state_d = last_q ? S_DONE : S_LOAD;
         end
         S_DONE: begin
            bus.done = 1'b1;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Write pointer, byte counter, overflow flag and the latched word.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q  <= '0;
         cnt_q  <= 2'd0;
         err_q  <= 1'b0;
         word_q <= 32'h0;
         last_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  ptr_q <= {1'b0, bus.base_addr};
                  err_q <= 1'b0;
               end
            end
            S_LOAD: begin
               if (bus.word_valid) begin
                  if (overflow) begin
                     err_q <= 1'b1;
                  end else begin
                     word_q <= bus.word_data;
                     last_q <= bus.word_last;
                     cnt_q  <= 2'd0;
                  end
               end
            end
            S_WRITE: begin
               ptr_q <= ptr_q + 1'b1;
               cnt_q <= cnt_q + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Big-endian byte selection: most significant byte goes to the lowest address.
   always_comb begin
      wbyte = 8'h00;
      case (cnt_q)
         2'd0: wbyte = word_q[31:24];
         2'd1: wbyte = word_q[23:16];
         2'd2: wbyte = word_q[15:8];
         2'd3: wbyte = word_q[7:0];
         default: wbyte = 8'h00;
      endcase
   end

   byte_memory #(
      .MEM_BYTES(MEM_BYTES),
      .ADDR_W   (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (we),
      .waddr (ptr_q[ADDR_W-1:0]),
      .wdata (wbyte),
      .raddr0(bus.rd_addr),
      .raddr1(bus.rd_addr + ADDR_W'(1)),
      .raddr2(bus.rd_addr + ADDR_W'(2)),
      .raddr3(bus.rd_addr + ADDR_W'(3)),
      .rdata0(rb0),
      .rdata1(rb1),
      .rdata2(rb2),
      .rdata3(rb3)
   );

   assign bus.rd_data   = {rb0, rb1, rb2, rb3};
   assign bus.err       = err_q;
   assign bus.next_addr = ptr_q[ADDR_W-1:0];
endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - self-checking bench for instruction_loader
module tb_instruction_loader;
   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   instruction_loader_if #(.ADDR_W(12)) bus ();

   instruction_loader #(.MEM_BYTES(4096), .ADDR_W(12)) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   typedef struct {
      logic [11:0] base;
      int          n;
      logic [31:0] w0, w1, w2;
      logic [11:0] exp_next;
      logic        exp_err;
      int          exp_done;
      logic [11:0] rd0;
      logic [31:0] exp0;
      logic [11:0] rd1;
      logic [31:0] exp1;
   } vec_t;

   int          n_cmp = 0;
   int          n_err = 0;
   int          last_done;
   logic [31:0] wq [$];
   logic [7:0]  ref_mem [4096];
   bit          known [4096];
   vec_t        vt [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_check(input int a);
      logic [31:0] e;
      bit ok;
      e  = 32'h0;
      ok = 1'b1;
      for (int j = 0; j < 4; j++) begin
         if (!known[(a + j) % 4096]) ok = 1'b0;
         e = {e[23:0], ref_mem[(a + j) % 4096]};
      end
      if (ok) begin
         bus.rd_addr = 12'(a);
         #1;
         chk("rd_data", bus.rd_data, e);
      end
   endtask

   // Runs one session of the words in wq with word_valid held high; the
   // reference model says which words land and when ready/done must appear.
   task automatic load(input logic [11:0] base, input bit noise);
      int n, addr, k, acc, d, idx, nd, done_at;
      bit ready_ok, busy_ok, exp_rdy;
      n = wq.size();
      addr = int'(base);
      k = -1;
      for (int i = 0; i < n; i++) begin
         if (addr > 4092) begin
            k = i;
            break;
         end
         for (int j = 0; j < 4; j++) begin
            ref_mem[addr + j] = wq[i][31 - 8*j -: 8];
            known[addr + j]   = 1'b1;
         end
         addr += 4;
      end
      acc = (k < 0) ? n : k + 1;
      d   = (k < 0) ? 5 * n : 5 * k + 1;
      idx = 0; nd = 0; done_at = -1; ready_ok = 1'b1; busy_ok = 1'b1;
      bus.start = 1'b1;
      bus.base_addr = base;
      bus.word_valid = 1'b0;
      tick();
      for (int cyc = 0; cyc <= d + 3; cyc++) begin
         bus.word_valid = (idx < n);
         bus.word_data  = (idx < n) ? wq[idx] : $urandom;
         bus.word_last  = (idx == n - 1);
         bus.start      = noise && (cyc < d);
         if (noise) bus.base_addr = 12'($urandom);
         @(negedge clk);
         exp_rdy = (cyc % 5 == 0) && (cyc / 5 < acc);
         if (bus.word_ready !== exp_rdy) ready_ok = 1'b0;
         if (bus.busy !== (cyc <= d)) busy_ok = 1'b0;
         if (bus.done === 1'b1) begin
            nd++;
            if (done_at < 0) done_at = cyc;
         end
         if (bus.word_ready === 1'b1 && idx < n) idx++;
         tick();
      end
      bus.word_valid = 1'b0;
      bus.start = 1'b0;
      chk("ready_pattern", 32'(ready_ok), 32'd1);
      chk("busy_pattern", 32'(busy_ok), 32'd1);
      chk("done_cycle", 32'(done_at), 32'(d));
      chk("done_width", 32'(nd), 32'd1);
      chk("next_addr", 32'(bus.next_addr), 32'(addr & 12'hFFF));
      chk("err", 32'(bus.err), 32'(k >= 0));
      last_done = done_at;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int b;
      bus.start = 1'b0; bus.base_addr = '0; bus.word_valid = 1'b0;
      bus.word_data = '0; bus.word_last = 1'b0; bus.rd_addr = '0;
      for (int i = 0; i < 4096; i++) known[i] = 1'b0;

      repeat (3) tick();
      reset = 1'b0;
      tick();
      chk("rst_word_ready", 32'(bus.word_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      chk("rst_next_addr", 32'(bus.next_addr), 32'd0);

      vt[0] = '{12'h000, 1, 32'h8C220004, 32'h0, 32'h0, 12'h004, 1'b0, 5, 12'h000, 32'h8C220004, 12'h000, 32'h8C220004};
      vt[1] = '{12'h100, 3, 32'h11111111, 32'h22222222, 32'h33333333, 12'h10C, 1'b0, 15, 12'h104, 32'h22222222, 12'h108, 32'h33333333};
      vt[2] = '{12'hFFC, 2, 32'hA1B2C3D4, 32'h55667788, 32'h0, 12'h000, 1'b1, 6, 12'hFFC, 32'hA1B2C3D4, 12'hFFE, 32'hC3D48C22};
      vt[3] = '{12'h202, 2, 32'hDEADBEEF, 32'h01234567, 32'h0, 12'h20A, 1'b0, 10, 12'h204, 32'hBEEF0123, 12'h206, 32'h01234567};
      vt[4] = '{12'hFFD, 1, 32'h99999999, 32'h0, 32'h0, 12'hFFD, 1'b1, 1, 12'hFFC, 32'hA1B2C3D4, 12'h000, 32'h8C220004};
      vt[5] = '{12'h010, 1, 32'hCAFEF00D, 32'h0, 32'h0, 12'h014, 1'b0, 5, 12'h010, 32'hCAFEF00D, 12'h0FE, 32'h0};

      for (int i = 0; i < 6; i++) begin
         wq = {};
         wq.push_back(vt[i].w0);
         if (vt[i].n > 1) wq.push_back(vt[i].w1);
         if (vt[i].n > 2) wq.push_back(vt[i].w2);
         load(vt[i].base, 1'b0);
         chk("tbl_next_addr", 32'(bus.next_addr), 32'(vt[i].exp_next));
         chk("tbl_err", 32'(bus.err), 32'(vt[i].exp_err));
         chk("tbl_done_cycle", 32'(last_done), 32'(vt[i].exp_done));
         bus.rd_addr = vt[i].rd0; #1;
         chk("tbl_rd0", bus.rd_data, vt[i].exp0);
         if (i != 5) begin
            bus.rd_addr = vt[i].rd1; #1;
            chk("tbl_rd1", bus.rd_data, vt[i].exp1);
         end
      end

      // Reset on the third write cycle of AABBCCDD at 0x20 over known 11223344.
      wq = {32'h11223344};
      load(12'h020, 1'b0);
      bus.start = 1'b1; bus.base_addr = 12'h020;
      tick();
      bus.start = 1'b0; bus.word_valid = 1'b1; bus.word_data = 32'hAABBCCDD; bus.word_last = 1'b1;
      tick();
      bus.word_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", 32'(bus.busy), 32'd0);
      chk("abort_next_addr", 32'(bus.next_addr), 32'd0);
      repeat (4) tick();
      bus.rd_addr = 12'h020; #1;
      chk("abort_mem", bus.rd_data, 32'hAABB3344);
      ref_mem[12'h020] = 8'hAA;
      ref_mem[12'h021] = 8'hBB;

      // word_valid presented in IDLE must be ignored.
      bus.word_valid = 1'b1; bus.word_data = 32'h5A5A5A5A; bus.word_last = 1'b1;
      begin
         bit idle_ok = 1'b1;
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.word_ready !== 1'b0 || bus.busy !== 1'b0) idle_ok = 1'b0;
            tick();
         end
         chk("idle_ignores_valid", 32'(idle_ok), 32'd1);
      end
      bus.word_valid = 1'b0;
      chk("idle_next_addr", 32'(bus.next_addr), 32'd0);
      rd_check(0);

      // start held during LOAD/WRITE with a junk base must not disturb the session.
      wq = {32'h0BADF00D, 32'h600DCAFE};
      load(12'h300, 1'b1);
      rd_check(12'h300);
      rd_check(12'h304);
      rd_check(0);

      // Randomised sessions against the reference model.
      for (int s = 0; s < 16; s++) begin
         wq = {};
         for (int w = 0; w < int'($urandom_range(1, 3)); w++) wq.push_back($urandom);
         b = ($urandom_range(0, 3) == 0) ? 4084 + int'($urandom_range(0, 11)) : int'($urandom_range(0, 4095));
         load(12'(b), 1'($urandom_range(0, 1)));
         rd_check(b);
         rd_check(b + 4);
         rd_check(int'($urandom_range(0, 4095)));
      end
      rd_check(12'hFFE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
